// File: rtl/ex_stage_ctrl.sv
// LEGv8 main control decoder fused with the execute/memory/writeback stage.
// Decodes instruction[31:21], runs the ALU, accesses doubleword data memory and registers writeback/branch results.
module ex_stage_ctrl #(
    parameter int unsigned DMEM_DEPTH = 64,
    parameter int unsigned DMEM_AW    = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [63:0] pc,
    input  logic [31:0] instruction,
    input  logic [63:0] sign_ext_imm,
    input  logic [63:0] read_data1,
    input  logic [63:0] read_data2,
    output logic        reg2loc,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [63:0] wb_data,
    output logic        alu_zero,
    output logic        pc_src,
    output logic [63:0] branch_address
);
    typedef enum logic [2:0] {FN_ADD, FN_SUB, FN_AND, FN_ORR, FN_PASS} alu_fn_e;

    logic [10:0] opcode;
    logic        reg2loc_c, br_c, bz_c, bnz_c;
    logic        mem_read_c, mem_to_reg_c, mem_write_c, reg_write_c;
    logic [1:0]  alu_op_c, alu_src_c;
    alu_fn_e     rtype_fn, alu_fn;
    logic [63:0] opb, alu_res, mem_rdata;
    logic        rd2_zero;
    logic [DMEM_AW-1:0] mem_idx;
    logic [63:0] dmem [DMEM_DEPTH];

    logic        wb_en_d, wb_en_q, alu_zero_d, alu_zero_q, pc_src_d, pc_src_q;
    logic [4:0]  wb_reg_d, wb_reg_q;
    logic [63:0] wb_data_d, wb_data_q, branch_address_d, branch_address_q;

    // Rn index is consumed by the register file in decode, not here.
    logic unused_rn;
    assign unused_rn = ^instruction[9:5];

    assign opcode = instruction[31:21];

    always_comb begin
        reg2loc_c    = 1'b0;
        br_c         = 1'b0;
        bz_c         = 1'b0;
        bnz_c        = 1'b0;
        mem_read_c   = 1'b0;
        mem_to_reg_c = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        alu_op_c     = 2'b00;
        alu_src_c    = 2'b00;
        rtype_fn     = FN_ADD;
        casez (opcode)
            11'b10001011000: begin alu_op_c = 2'b10; reg_write_c = 1'b1; rtype_fn = FN_ADD; end
            11'b11001011000: begin alu_op_c = 2'b10; reg_write_c = 1'b1; rtype_fn = FN_SUB; end
            11'b10001010000: begin alu_op_c = 2'b10; reg_write_c = 1'b1; rtype_fn = FN_AND; end
            11'b10101010000: begin alu_op_c = 2'b10; reg_write_c = 1'b1; rtype_fn = FN_ORR; end
            11'b1001000100?: begin
                alu_op_c = 2'b11; alu_src_c = 2'b10; reg_write_c = 1'b1; rtype_fn = FN_ADD;
            end
            11'b1101000100?: begin
                alu_op_c = 2'b11; alu_src_c = 2'b10; reg_write_c = 1'b1; rtype_fn = FN_SUB;
            end
            11'b11111000010: begin
                alu_src_c = 2'b01; mem_read_c = 1'b1; mem_to_reg_c = 1'b1; reg_write_c = 1'b1;
            end
            11'b11111000000: begin alu_src_c = 2'b01; reg2loc_c = 1'b1; mem_write_c = 1'b1; end
            11'b10110100???: begin alu_op_c = 2'b01; reg2loc_c = 1'b1; bz_c = 1'b1; end
            11'b10110101???: begin alu_op_c = 2'b01; reg2loc_c = 1'b1; bnz_c = 1'b1; end
            11'b000101?????: br_c = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (alu_src_c)
            2'b01:   opb = sign_ext_imm;
            2'b10:   opb = {52'b0, instruction[21:10]};
            default: opb = read_data2;
        endcase
        case (alu_op_c)
            2'b00:   alu_fn = FN_ADD;
            2'b01:   alu_fn = FN_PASS;
            default: alu_fn = rtype_fn;
        endcase
        case (alu_fn)
            FN_SUB:  alu_res = read_data1 - opb;
            FN_AND:  alu_res = read_data1 & opb;
            FN_ORR:  alu_res = read_data1 | opb;
            FN_PASS: alu_res = read_data2;
            default: alu_res = read_data1 + opb;
        endcase
    end

    // Byte offset bits and out-of-range upper bits are dropped, so the index wraps.
    assign mem_idx   = alu_res[DMEM_AW+2:3];
    assign mem_rdata = dmem[mem_idx];
    assign rd2_zero  = (read_data2 == '0);

    always_ff @(posedge clk) begin
        if (!rst && instr_valid && mem_write_c) begin
            dmem[mem_idx] <= read_data2;
        end
    end

    always_comb begin
        wb_en_d          = 1'b0;
        pc_src_d         = 1'b0;
        wb_reg_d         = wb_reg_q;
        wb_data_d        = wb_data_q;
        alu_zero_d       = alu_zero_q;
        branch_address_d = branch_address_q;
        if (instr_valid) begin
            wb_en_d          = reg_write_c && (instruction[4:0] != 5'd31);
            wb_reg_d         = instruction[4:0];
            wb_data_d        = mem_to_reg_c ? mem_rdata : alu_res;
            alu_zero_d       = (alu_res == '0);
            pc_src_d         = br_c | (bz_c & rd2_zero) | (bnz_c & ~rd2_zero);
            branch_address_d = pc + (sign_ext_imm << 2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en_q          <= 1'b0;
            wb_reg_q         <= '0;
            wb_data_q        <= '0;
            alu_zero_q       <= 1'b0;
            pc_src_q         <= 1'b0;
            branch_address_q <= '0;
        end else begin
            wb_en_q          <= wb_en_d;
            wb_reg_q         <= wb_reg_d;
            wb_data_q        <= wb_data_d;
            alu_zero_q       <= alu_zero_d;
            pc_src_q         <= pc_src_d;
            branch_address_q <= branch_address_d;
        end
    end

    assign reg2loc        = reg2loc_c;
    assign wb_en          = wb_en_q;
    assign wb_reg         = wb_reg_q;
    assign wb_data        = wb_data_q;
    assign alu_zero       = alu_zero_q;
    assign pc_src         = pc_src_q;
    assign branch_address = branch_address_q;

    logic unused_mem_read;
    assign unused_mem_read = mem_read_c;
endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Directed vector table plus randomized instruction stream checked against a behavioural model.
module tb_ex_stage_ctrl;
    logic        clk = 1'b0;
    logic        rst, instr_valid, reg2loc, wb_en, alu_zero, pc_src;
    logic [63:0] pc, sign_ext_imm, read_data1, read_data2, wb_data, branch_address;
    logic [31:0] instruction;
    logic [4:0]  wb_reg;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    ex_stage_ctrl #(.DMEM_DEPTH(64), .DMEM_AW(6)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc(pc), .instruction(instruction),
        .sign_ext_imm(sign_ext_imm), .read_data1(read_data1), .read_data2(read_data2),
        .reg2loc(reg2loc), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .alu_zero(alu_zero), .pc_src(pc_src), .branch_address(branch_address)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, v;
        logic [63:0] p;
        logic [31:0] ins;
        logic [63:0] im, a, b;
        logic        r2l, en;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        z, ps;
        logic [63:0] ba;
    } vec_t;
    vec_t vq[$];

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        z, ps;
        logic [63:0] ba;
    } outs_t;
    outs_t       m;
    logic [63:0] mdl_mem [64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic apply(input logic r, v, input logic [63:0] p, input logic [31:0] ins,
                         input logic [63:0] im, a, b);
        @(negedge clk);
        rst = r; instr_valid = v; pc = p; instruction = ins;
        sign_ext_imm = im; read_data1 = a; read_data2 = b;
        #1;
    endtask

    task automatic chk_outs(input string tag, input outs_t e);
        chk({tag, ".wb_en"}, {63'd0, wb_en}, {63'd0, e.en});
        chk({tag, ".wb_reg"}, {59'd0, wb_reg}, {59'd0, e.rd});
        chk({tag, ".wb_data"}, wb_data, e.data);
        chk({tag, ".alu_zero"}, {63'd0, alu_zero}, {63'd0, e.z});
        chk({tag, ".pc_src"}, {63'd0, pc_src}, {63'd0, e.ps});
        chk({tag, ".branch_address"}, branch_address, e.ba);
    endtask

    // Behavioural model: classify per the opcode table, compute the result directly,
    // update expected registered state; returns the expected reg2loc.
    function automatic logic model_edge(input logic r, v, input logic [63:0] p,
                                        input logic [31:0] ins, input logic [63:0] imm, a, b);
        logic [63:0] res  = a + b;
        logic [63:0] uimm = {52'd0, ins[21:10]};
        logic wr = 0, ld = 0, st = 0, br = 0, bz = 0, bnz = 0;
        casez (ins[31:21])
            11'b10001011000: begin res = a + b;    wr = 1; end
            11'b11001011000: begin res = a - b;    wr = 1; end
            11'b10001010000: begin res = a & b;    wr = 1; end
            11'b10101010000: begin res = a | b;    wr = 1; end
            11'b1001000100?: begin res = a + uimm; wr = 1; end
            11'b1101000100?: begin res = a - uimm; wr = 1; end
            11'b11111000010: begin res = a + imm;  wr = 1; ld = 1; end
            11'b11111000000: begin res = a + imm;  st = 1; end
            11'b10110100???: begin res = b; bz = 1; end
            11'b10110101???: begin res = b; bnz = 1; end
            11'b000101?????: br = 1;
            default: ;
        endcase
        if (r) m = '0;
        else if (v) begin
            m.en   = wr && (ins[4:0] != 5'd31);
            m.rd   = ins[4:0];
            m.data = ld ? mdl_mem[res[8:3]] : res;
            m.z    = (res == 64'd0);
            m.ps   = br || (bz && b == 64'd0) || (bnz && b != 64'd0);
            m.ba   = p + imm * 4;
            if (st) mdl_mem[res[8:3]] = b;
        end else begin
            m.en = 0;
            m.ps = 0;
        end
        return st || bz || bnz;
    endfunction

    initial begin
        logic [31:0] r32, ins;
        logic [63:0] a, b, im;
        logic        r2l_exp, rr, vv;
        vec_t        t;
        outs_t       e;

        //        rst  vld pc       instr          imm               d1            d2                     r2l en rd     data                    z  ps ba
        vq.push_back('{1, 0, 64'h0,   32'h0,        64'h0,            64'h0,        64'h0,                 0, 0, 5'd0,  64'h0,                  0, 0, 64'h0});
        vq.push_back('{0, 1, 64'h0,   32'hF8008022, 64'h8,            64'h10,       64'hCAFE,              1, 0, 5'd2,  64'h18,                 0, 0, 64'h20});
        vq.push_back('{1, 1, 64'h0,   32'hF8008022, 64'h8,            64'h10,       64'h5555,              1, 0, 5'd0,  64'h0,                  0, 0, 64'h0});
        vq.push_back('{0, 1, 64'h0,   32'hF8408026, 64'h8,            64'h10,       64'h0,                 0, 1, 5'd6,  64'hCAFE,               0, 0, 64'h20});
        vq.push_back('{0, 1, 64'h0,   32'hF8008022, 64'h8,            64'h10,       64'hDEADBEEF,          1, 0, 5'd2,  64'h18,                 0, 0, 64'h20});
        vq.push_back('{0, 1, 64'h0,   32'hF8408026, 64'h8,            64'h10,       64'h0,                 0, 1, 5'd6,  64'hDEADBEEF,           0, 0, 64'h20});
        vq.push_back('{0, 1, 64'h0,   32'h8B020023, 64'h0,            64'd5,        64'd7,                 0, 1, 5'd3,  64'd12,                 0, 0, 64'h0});
        vq.push_back('{0, 1, 64'h0,   32'hD1001424, 64'h0,            64'd5,        64'd0,                 0, 1, 5'd4,  64'd0,                  1, 0, 64'h0});
        vq.push_back('{0, 1, 64'h0,   32'hD100143F, 64'h0,            64'd5,        64'd0,                 0, 0, 5'd31, 64'd0,                  1, 0, 64'h0});
        vq.push_back('{0, 0, 64'h40,  32'h8B020023, 64'h1,            64'd1,        64'd1,                 0, 0, 5'd31, 64'd0,                  1, 0, 64'h0});
        vq.push_back('{0, 1, 64'h100, 32'hB4000082, 64'h4,            64'd0,        64'd0,                 1, 0, 5'd2,  64'd0,                  1, 1, 64'h110});
        vq.push_back('{0, 1, 64'h100, 32'hB4000082, 64'h4,            64'd0,        64'd1,                 1, 0, 5'd2,  64'd1,                  0, 0, 64'h110});
        vq.push_back('{0, 1, 64'h100, 32'hB5000082, 64'h4,            64'd0,        64'd0,                 1, 0, 5'd2,  64'd0,                  1, 0, 64'h110});
        vq.push_back('{0, 1, 64'h100, 32'hB5000082, 64'h4,            64'd0,        64'd1,                 1, 0, 5'd2,  64'd1,                  0, 1, 64'h110});
        vq.push_back('{0, 0, 64'h500, 32'hB5000082, 64'h9,            64'd0,        64'd1,                 1, 0, 5'd2,  64'd1,                  0, 0, 64'h110});
        vq.push_back('{0, 1, 64'h200, 32'h17FFFFFE, 64'hFFFFFFFFFFFFFFFE, 64'd3,    64'd4,                 0, 0, 5'd30, 64'd7,                  0, 1, 64'h1F8});
        vq.push_back('{0, 1, 64'h300, 32'hFFFFFFFF, 64'h0,            64'd0,        64'd0,                 0, 0, 5'd31, 64'd0,                  1, 0, 64'h300});
        vq.push_back('{0, 1, 64'h0,   32'h8A020023, 64'h0,            64'hF0F0,     64'h0FF0,              0, 1, 5'd3,  64'h00F0,               0, 0, 64'h0});
        vq.push_back('{0, 1, 64'h0,   32'hAA020023, 64'h0,            64'hF0,       64'h0F,                0, 1, 5'd3,  64'hFF,                 0, 0, 64'h0});
        vq.push_back('{0, 1, 64'h0,   32'hCB020023, 64'h0,            64'd3,        64'd5,                 0, 1, 5'd3,  64'hFFFFFFFFFFFFFFFE,   0, 0, 64'h0});

        foreach (vq[i]) begin
            t = vq[i];
            apply(t.r, t.v, t.p, t.ins, t.im, t.a, t.b);
            chk($sformatf("vec%0d.reg2loc", i), {63'd0, reg2loc}, {63'd0, t.r2l});
            @(posedge clk); #1;
            e = '{t.en, t.rd, t.data, t.z, t.ps, t.ba};
            chk_outs($sformatf("vec%0d", i), e);
        end

        // Random phase: reset, fill every memory word, then a mixed instruction stream.
        apply(1, 1, 64'h0, 32'h0, 64'h0, 64'h0, 64'h0);
        void'(model_edge(1, 1, 64'h0, 32'h0, 64'h0, 64'h0, 64'h0));
        @(posedge clk); #1;
        chk_outs("rnd_reset", m);

        for (int unsigned i = 0; i < 64; i++) begin
            b = {$urandom(), $urandom()};
            a = 64'(i * 8);
            apply(0, 1, 64'h0, 32'hF8000022, 64'h0, a, b);
            r2l_exp = model_edge(0, 1, 64'h0, 32'hF8000022, 64'h0, a, b);
            chk($sformatf("fill%0d.reg2loc", i), {63'd0, reg2loc}, {63'd0, r2l_exp});
            @(posedge clk); #1;
            chk_outs($sformatf("fill%0d", i), m);
        end

        for (int unsigned i = 0; i < 400; i++) begin
            r32 = $urandom();
            case ($urandom_range(0, 11))
                0:  ins = {11'b10001011000, r32[20:0]};
                1:  ins = {11'b11001011000, r32[20:0]};
                2:  ins = {11'b10001010000, r32[20:0]};
                3:  ins = {11'b10101010000, r32[20:0]};
                4:  ins = {10'b1001000100, r32[21:0]};
                5:  ins = {10'b1101000100, r32[21:0]};
                6:  ins = {11'b11111000010, r32[20:0]};
                7:  ins = {11'b11111000000, r32[20:0]};
                8:  ins = {8'b10110100, r32[23:0]};
                9:  ins = {8'b10110101, r32[23:0]};
                10: ins = {6'b000101, r32[25:0]};
                default: ins = $urandom();
            endcase
            if ($urandom_range(0, 7) == 0) ins[4:0] = 5'd31;
            a  = {$urandom(), $urandom()};
            b  = {$urandom(), $urandom()};
            im = ($urandom_range(0, 1) == 0) ? {$urandom(), $urandom()} : 64'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) b = 64'd0;
            if ($urandom_range(0, 7) == 0) b = a;
            if ($urandom_range(0, 7) == 0) a = 64'({ins[21:10]});
            rr = ($urandom_range(0, 31) == 0);
            vv = ($urandom_range(0, 4) != 0);
            apply(rr, vv, {$urandom(), $urandom()}, ins, im, a, b);
            r2l_exp = model_edge(rr, vv, pc, ins, im, a, b);
            chk($sformatf("rnd%0d.reg2loc", i), {63'd0, reg2loc}, {63'd0, r2l_exp});
            @(posedge clk); #1;
            chk_outs($sformatf("rnd%0d", i), m);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
